seq_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller. It takes a configuration and a start pulse from a host. It then consumes a bounded window of serial bits over a valid/ready handshake and detects a pattern of 1 to MAX_LEN bits in overlapping or non-overlapping mode. It reports a per-hit pulse, a hit count, the index of the first hit, and a completion pulse, and sits between the bit-stream source and the host that schedules detection runs.

---
 rtl/seq_detect_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//
// Programmable serial-pattern detection controller. A host configures a
// pattern (1..MAX_LEN bits), overlap mode, window length and hit limit, then
// pulses start. The block consumes up to cfg_window bits over a valid/ready
// handshake, pulses hit for every match and reports the hit count, the index
// of the first matching bit and a one-cycle done pulse at the end of the run.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, abort        run control (start sampled in IDLE, abort in RUN)
//   cfg_pattern         pattern, bit cfg_len-1 is the first bit expected
//   cfg_len             pattern length, 0 -> 1, >MAX_LEN -> MAX_LEN
//   cfg_overlap         1 = overlapping matches allowed
//   cfg_window          number of bits to consume (0 = empty run)
//   cfg_max_hits        stop after this many hits (0 = unlimited)
//   in_valid, in_bit    serial stream input
//   in_ready            bit accepted when in_valid & in_ready (RUN only)
//   busy                high in RUN and DONE
//   hit                 one-cycle pulse per match
//   hit_count           matches in the current/last run (saturating)
//   first_hit_vld/_idx  0-based index of the bit completing the first match
//   done                one-cycle pulse at run end
//   aborted             last run was ended by abort
//   state_o             FSM state: IDLE=0, RUN=1, DONE=2
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [3:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_window,
   input  logic [CNT_W-1:0]   cfg_max_hits,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               in_ready,
   output logic               busy,
   output logic               hit,
   output logic [CNT_W-1:0]   hit_count,
   output logic               first_hit_vld,
   output logic [CNT_W-1:0]   first_hit_idx,
   output logic               done,
   output logic               aborted,
   output logic [1:0]         state_o
);

   localparam int FW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;

   // Configuration captured at start
   logic [MAX_LEN-1:0] pat_reg, pat_next;
   logic [3:0]         len_reg, len_next;
   logic               overlap_reg, overlap_next;
   logic [CNT_W-1:0]   window_reg, window_next;
   logic [CNT_W-1:0]   max_hits_reg, max_hits_next;

   // Datapath state
   logic [MAX_LEN-1:0] hist_reg, hist_next;
   logic [FW-1:0]      fill_reg, fill_next;
   logic [CNT_W-1:0]   bitcnt_reg, bitcnt_next;
   logic               hit_reg, hit_next;
   logic [CNT_W-1:0]   hit_count_reg, hit_count_next;
   logic               first_vld_reg, first_vld_next;
   logic [CNT_W-1:0]   first_idx_reg, first_idx_next;
   logic               aborted_reg, aborted_next;

   // Combinational helpers
   logic [3:0]         len_clamped;
   logic [MAX_LEN-1:0] hist_new;
   logic [FW-1:0]      fill_new;
   logic [MAX_LEN-1:0] len_mask;
   logic               accept;
   logic               match;
   logic               last_bit;
   logic               max_reached;
   logic [CNT_W-1:0]   hit_count_inc;

   assign len_clamped = (cfg_len == 4'd0)            ? 4'd1 :
                        (cfg_len > 4'(MAX_LEN))      ? 4'(MAX_LEN) : cfg_len;

   assign accept   = (state_reg == RUN) && in_valid;
   assign hist_new = MAX_LEN'({hist_reg, in_bit});
   assign fill_new = (fill_reg == FW'(MAX_LEN)) ? fill_reg : fill_reg + FW'(1);

   // Only the low len bits of history and pattern take part in the compare
   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
         assign len_mask[gi] = (len_reg > 4'(gi));
      end
   endgenerate

   // fill counts bits seen since the last reset of the history, so a match
   // needs at least len fresh bits (also enforces the non-overlap restart)
   assign match = (FW'(len_reg) <= fill_new) &&
                  (((hist_new ^ pat_reg) & len_mask) == '0);

   // The bit being accepted is index bitcnt_reg; window is nonzero in RUN
   assign last_bit      = (bitcnt_reg == window_reg - CNT_W'(1));
   assign max_reached   = (max_hits_reg != '0) &&
                          ((hit_count_reg + CNT_W'(1)) == max_hits_reg);
   assign hit_count_inc = (hit_count_reg == '1) ? hit_count_reg
                                                : hit_count_reg + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pat_reg       <= '0;
         len_reg       <= 4'd1;
         overlap_reg   <= 1'b0;
         window_reg    <= '0;
         max_hits_reg  <= '0;
         hist_reg      <= '0;
         fill_reg      <= '0;
         bitcnt_reg    <= '0;
         hit_reg       <= 1'b0;
         hit_count_reg <= '0;
         first_vld_reg <= 1'b0;
         first_idx_reg <= '0;
         aborted_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pat_reg       <= pat_next;
         len_reg       <= len_next;
         overlap_reg   <= overlap_next;
         window_reg    <= window_next;
         max_hits_reg  <= max_hits_next;
         hist_reg      <= hist_next;
         fill_reg      <= fill_next;
         bitcnt_reg    <= bitcnt_next;
         hit_reg       <= hit_next;
         hit_count_reg <= hit_count_next;
         first_vld_reg <= first_vld_next;
         first_idx_reg <= first_idx_next;
         aborted_reg   <= aborted_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pat_next       = pat_reg;
      len_next       = len_reg;
      overlap_next   = overlap_reg;
      window_next    = window_reg;
      max_hits_next  = max_hits_reg;
      hist_next      = hist_reg;
      fill_next      = fill_reg;
      bitcnt_next    = bitcnt_reg;
      hit_next       = 1'b0;
      hit_count_next = hit_count_reg;
      first_vld_next = first_vld_reg;
      first_idx_next = first_idx_reg;
      aborted_next   = aborted_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               pat_next       = cfg_pattern;
               len_next       = len_clamped;
               overlap_next   = cfg_overlap;
               window_next    = cfg_window;
               max_hits_next  = cfg_max_hits;
               hist_next      = '0;
               fill_next      = '0;
               bitcnt_next    = '0;
               hit_count_next = '0;
               first_vld_next = 1'b0;
               first_idx_next = '0;
               aborted_next   = 1'b0;
               state_next     = (cfg_window == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               hist_next   = hist_new;
               fill_next   = fill_new;
               bitcnt_next = bitcnt_reg + CNT_W'(1);
               if (match) begin
                  hit_next       = 1'b1;
                  hit_count_next = hit_count_inc;
                  if (!first_vld_reg) begin
                     first_vld_next = 1'b1;
                     first_idx_next = bitcnt_reg;
                  end
                  if (!overlap_reg) begin
                     fill_next = '0;
                  end
               end
               if (last_bit || (match && max_reached)) begin
                  state_next = DONE;
               end
            end
            // A bit accepted alongside abort was processed above
            if (abort) begin
               aborted_next = 1'b1;
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready      = (state_reg == RUN);
   assign busy          = (state_reg == RUN) || (state_reg == DONE);
   assign done          = (state_reg == DONE);
   assign hit           = hit_reg;
   assign hit_count     = hit_count_reg;
   assign first_hit_vld = first_vld_reg;
   assign first_hit_idx = first_idx_reg;
   assign aborted       = aborted_reg;
   assign state_o       = state_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed bench for seq_detect_ctrl: overlap / non-overlap detection,
// max-hit stop, backpressure with abort, empty window, zero length, and
// reset in the middle of a run. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               abort;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [3:0]         cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_window;
   logic [CNT_W-1:0]   cfg_max_hits;
   logic               in_valid;
   logic               in_bit;
   logic               in_ready;
   logic               busy;
   logic               hit;
   logic [CNT_W-1:0]   hit_count;
   logic               first_hit_vld;
   logic [CNT_W-1:0]   first_hit_idx;
   logic               done;
   logic               aborted;
   logic [1:0]         state_o;

   int checks = 0;
   int errors = 0;
   int bit_no = 0;

   always #5 clk = ~clk;

   seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .cfg_pattern   (cfg_pattern),
      .cfg_len       (cfg_len),
      .cfg_overlap   (cfg_overlap),
      .cfg_window    (cfg_window),
      .cfg_max_hits  (cfg_max_hits),
      .in_valid      (in_valid),
      .in_bit        (in_bit),
      .in_ready      (in_ready),
      .busy          (busy),
      .hit           (hit),
      .hit_count     (hit_count),
      .first_hit_vld (first_hit_vld),
      .first_hit_idx (first_hit_idx),
      .done          (done),
      .aborted       (aborted),
      .state_o       (state_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, ".state"},     32'(state_o),       32'd0);
      check({tag, ".in_ready"},  32'(in_ready),      32'd0);
      check({tag, ".busy"},      32'(busy),          32'd0);
      check({tag, ".hit"},       32'(hit),           32'd0);
      check({tag, ".hit_count"}, 32'(hit_count),     32'd0);
      check({tag, ".first_vld"}, 32'(first_hit_vld), 32'd0);
      check({tag, ".first_idx"}, 32'(first_hit_idx), 32'd0);
      check({tag, ".done"},      32'(done),          32'd0);
      check({tag, ".aborted"},   32'(aborted),       32'd0);
   endtask

   task automatic do_start(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                           input logic [7:0] win, input logic [7:0] mh);
      cfg_pattern  = pat;
      cfg_len      = len;
      cfg_overlap  = ov;
      cfg_window   = win;
      cfg_max_hits = mh;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      bit_no       = 0;
      $display("start pat=%b len=%0d ov=%0d win=%0d max=%0d -> state=%0d",
               pat, len, ov, win, mh, state_o);
   endtask

   // Offer one valid bit for one cycle, then check the hit pulse
   task automatic send_bit(input logic b, input logic exp_hit, input string tag);
      in_valid = 1'b1;
      in_bit   = b;
      tick();
      in_valid = 1'b0;
      $display("bit idx=%0d in=%0d hit=%0d count=%0d state=%0d",
               bit_no, b, hit, hit_count, state_o);
      check(tag, 32'(hit), 32'(exp_hit));
      bit_no++;
   endtask

   // Seven-bit stream sent oldest first; bits[6] is index 0
   task automatic run_stream7(input logic [6:0] bits, input logic [6:0] hits, input string tag);
      for (int i = 0; i < 7; i++) begin
         send_bit(bits[6-i], hits[6-i], $sformatf("%s.hit%0d", tag, i));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      cfg_window = '0; cfg_max_hits = '0; in_valid = 1'b0; in_bit = 1'b0;
      tick(); tick();
      check_idle_zero("reset");
      rst = 1'b0;
      tick();

      // ---- overlap: 1011 in 1,0,1,1,0,1,1 -> hits at idx 3 and 6 ----
      do_start(8'b0000_1011, 4'd4, 1'b1, 8'd7, 8'd0);
      check("ovl.state_run", 32'(state_o), 32'd1);
      check("ovl.in_ready",  32'(in_ready), 32'd1);
      check("ovl.busy",      32'(busy), 32'd1);
      // cfg changes after start must not affect the run
      cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_window = 8'd2; cfg_overlap = 1'b0;
      run_stream7(7'b1011011, 7'b0001001, "ovl");
      check("ovl.state_done", 32'(state_o), 32'd2);
      check("ovl.done",       32'(done), 32'd1);
      check("ovl.in_ready0",  32'(in_ready), 32'd0);
      check("ovl.count",      32'(hit_count), 32'd2);
      check("ovl.first_vld",  32'(first_hit_vld), 32'd1);
      check("ovl.first_idx",  32'(first_hit_idx), 32'd3);
      tick();
      check("ovl.idle",       32'(state_o), 32'd0);
      check("ovl.done_pulse", 32'(done), 32'd0);
      check("ovl.count_hold", 32'(hit_count), 32'd2);

      // ---- non-overlap: same stream -> single hit at idx 3 ----
      do_start(8'b0000_1011, 4'd4, 1'b0, 8'd7, 8'd0);
      run_stream7(7'b1011011, 7'b0001000, "novl");
      check("novl.state_done", 32'(state_o), 32'd2);
      check("novl.done",       32'(done), 32'd1);
      check("novl.count",      32'(hit_count), 32'd1);
      check("novl.first_idx",  32'(first_hit_idx), 32'd3);
      tick();

      // ---- max hits: 11 on all-ones, stop after 3 hits (4 bits) ----
      do_start(8'b0000_0011, 4'd2, 1'b1, 8'd10, 8'd3);
      send_bit(1'b1, 1'b0, "mh.hit0");
      send_bit(1'b1, 1'b1, "mh.hit1");
      check("mh.state_run", 32'(state_o), 32'd1);
      send_bit(1'b1, 1'b1, "mh.hit2");
      send_bit(1'b1, 1'b1, "mh.hit3");
      check("mh.state_done", 32'(state_o), 32'd2);
      check("mh.done",       32'(done), 32'd1);
      check("mh.in_ready0",  32'(in_ready), 32'd0);
      check("mh.count",      32'(hit_count), 32'd3);
      check("mh.first_idx",  32'(first_hit_idx), 32'd1);
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
      check("mh.idle",       32'(state_o), 32'd0);
      check("mh.in_ready1",  32'(in_ready), 32'd0);
      check("mh.count_hold", 32'(hit_count), 32'd3);
      check("mh.no_hit",     32'(hit), 32'd0);
      in_valid = 1'b0;
      tick();

      // ---- backpressure + abort: pattern '1', invalid cycles carry 1s ----
      do_start(8'b0000_0001, 4'd1, 1'b1, 8'd20, 8'd0);
      for (int i = 0; i < 3; i++) begin
         send_bit((i == 2) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0, $sformatf("bp.hit%0d", i));
         // stall cycle; start with window 0 must be ignored while running
         in_valid = 1'b0; in_bit = 1'b1; start = 1'b1; cfg_window = 8'd0;
         tick();
         start = 1'b0;
         check($sformatf("bp.stall_hit%0d", i), 32'(hit), 32'd0);
         check($sformatf("bp.stall_run%0d", i), 32'(state_o), 32'd1);
      end
      check("bp.first_idx", 32'(first_hit_idx), 32'd2);
      check("bp.count1",    32'(hit_count), 32'd1);
      // abort together with an accepted bit: the bit still counts
      abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      $display("abort -> state=%0d aborted=%0d count=%0d", state_o, aborted, hit_count);
      check("bp.state_done", 32'(state_o), 32'd2);
      check("bp.done",       32'(done), 32'd1);
      check("bp.aborted",    32'(aborted), 32'd1);
      check("bp.abort_hit",  32'(hit), 32'd1);
      check("bp.count2",     32'(hit_count), 32'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("bp.start_in_done_ignored", 32'(state_o), 32'd0);
      check("bp.aborted_hold", 32'(aborted), 32'd1);
      check("bp.count_hold",   32'(hit_count), 32'd2);
      check("bp.idx_hold",     32'(first_hit_idx), 32'd2);
      tick();
      check("bp.still_idle",   32'(state_o), 32'd0);

      // ---- window 0: done in the cycle after start ----
      do_start(8'b0000_0001, 4'd1, 1'b1, 8'd0, 8'd0);
      check("w0.state_done", 32'(state_o), 32'd2);
      check("w0.done",       32'(done), 32'd1);
      check("w0.busy",       32'(busy), 32'd1);
      check("w0.in_ready",   32'(in_ready), 32'd0);
      check("w0.count",      32'(hit_count), 32'd0);
      check("w0.aborted_clr", 32'(aborted), 32'd0);
      check("w0.first_vld",  32'(first_hit_vld), 32'd0);
      tick();
      check("w0.idle",       32'(state_o), 32'd0);

      // ---- len 0 treated as 1: pattern bit0=1 on 1,0,1 ----
      do_start(8'b0000_0001, 4'd0, 1'b1, 8'd3, 8'd0);
      send_bit(1'b1, 1'b1, "len0.hit0");
      send_bit(1'b0, 1'b0, "len0.hit1");
      send_bit(1'b1, 1'b1, "len0.hit2");
      check("len0.state_done", 32'(state_o), 32'd2);
      check("len0.count",      32'(hit_count), 32'd2);
      check("len0.first_idx",  32'(first_hit_idx), 32'd0);
      tick();

      // ---- reset mid-run after two accepted bits ----
      do_start(8'b0000_1011, 4'd4, 1'b1, 8'd7, 8'd0);
      send_bit(1'b1, 1'b0, "rst.hit0");
      send_bit(1'b0, 1'b0, "rst.hit1");
      rst = 1'b1;
      tick();
      check_idle_zero("rst_mid");
      rst = 1'b0;
      tick();
      check("rst.no_done", 32'(done), 32'd0);
      do_start(8'b0000_1011, 4'd4, 1'b1, 8'd7, 8'd0);
      run_stream7(7'b1011011, 7'b0001001, "fresh");
      check("fresh.done",      32'(done), 32'd1);
      check("fresh.count",     32'(hit_count), 32'd2);
      check("fresh.first_idx", 32'(first_hit_idx), 32'd3);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
